// File: rtl/payoff_accum_pkg.sv
// rtl/payoff_accum_pkg.sv - shared FP12 constants, FSM states and mode encodings
package payoff_accum_pkg;

    localparam int FP12_W    = 12;
    localparam int FP12_FRAC = 8;

    localparam logic MODE_EURO  = 1'b0;
    localparam logic MODE_ASIAN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/payoff_accum_payoff_calc.sv
// rtl/payoff_accum_payoff_calc.sv - combinational call payoff max(underlying - strike, 0)
module payoff_calc
    import payoff_accum_pkg::*;
(
    input  logic [FP12_W-1:0] underlying_i,
    input  logic [FP12_W-1:0] strike_i,
    output logic [FP12_W-1:0] payoff_o
);

    assign payoff_o = (underlying_i > strike_i) ? (underlying_i - strike_i) : '0;

endmodule

// File: rtl/payoff_accum.sv
// rtl/payoff_accum.sv - per-path option payoff and Monte-Carlo mean over NUM_PATHS paths
module payoff_accum
    import payoff_accum_pkg::*;
#(
    parameter int NUM_OF_DAYS = 8,
    parameter int NUM_PATHS   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FP12_W-1:0] strike,
    input  logic              mode,
    input  logic              path_valid,
    input  logic [FP12_W-1:0] path,
    output logic              payoff_valid,
    output logic [FP12_W-1:0] payoff,
    output logic              busy,
    output logic              done,
    output logic [FP12_W-1:0] price
);

    localparam int LOG2_DAYS  = $clog2(NUM_OF_DAYS);
    localparam int LOG2_PATHS = $clog2(NUM_PATHS);
    localparam int SUM_W      = FP12_W + LOG2_DAYS;
    localparam int ACC_W      = FP12_W + LOG2_PATHS;

    localparam logic [LOG2_DAYS-1:0]  LAST_DAY  = LOG2_DAYS'(NUM_OF_DAYS - 1);
    localparam logic [LOG2_PATHS-1:0] LAST_PATH = LOG2_PATHS'(NUM_PATHS - 1);

    state_e                  state_q, state_d;
    logic [LOG2_DAYS-1:0]    day_cnt_q, day_cnt_d;
    logic [LOG2_PATHS-1:0]   path_cnt_q, path_cnt_d;
    logic [SUM_W-1:0]        sum_q, sum_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [FP12_W-1:0]       payoff_q, payoff_d;
    logic                    payoff_valid_q, payoff_valid_d;
    logic [FP12_W-1:0]       strike_q, strike_d;
    logic                    mode_q, mode_d;

    logic [SUM_W-1:0]        sum_plus;
    logic [FP12_W-1:0]       avg;
    logic [LOG2_DAYS-1:0]    avg_frac_unused;
    logic [FP12_W-1:0]       underlying;
    logic [FP12_W-1:0]       calc_payoff;

    // The average is the running sum including the maturity beat, truncated by the day shift.
    assign sum_plus                 = sum_q + SUM_W'(path);
    assign {avg, avg_frac_unused}   = sum_plus;
    assign underlying               = (mode_q == MODE_ASIAN) ? avg : path;

    payoff_calc u_payoff_calc (
        .underlying_i (underlying),
        .strike_i     (strike_q),
        .payoff_o     (calc_payoff)
    );

    always_comb begin
        state_d        = state_q;
        day_cnt_d      = day_cnt_q;
        path_cnt_d     = path_cnt_q;
        sum_d          = sum_q;
        acc_d          = acc_q;
        payoff_d       = payoff_q;
        payoff_valid_d = 1'b0;
        strike_d       = strike_q;
        mode_d         = mode_q;

        // start wins in every state: it also drops a pending payoff and any same-cycle beat.
        if (start) begin
            state_d    = ST_ACCUM;
            day_cnt_d  = '0;
            path_cnt_d = '0;
            sum_d      = '0;
            acc_d      = '0;
            strike_d   = strike;
            mode_d     = mode;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (payoff_valid_q) begin
                        acc_d      = acc_q + ACC_W'(payoff_q);
                        path_cnt_d = path_cnt_q + 1'b1;
                        if (path_cnt_q == LAST_PATH) begin
                            state_d = ST_DONE;
                        end
                    end
                    if (path_valid) begin
                        if (day_cnt_q == LAST_DAY) begin
                            payoff_d       = calc_payoff;
                            payoff_valid_d = 1'b1;
                            sum_d          = '0;
                            day_cnt_d      = '0;
                        end else begin
                            sum_d     = sum_plus;
                            day_cnt_d = day_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_cnt_q      <= '0;
            path_cnt_q     <= '0;
            sum_q          <= '0;
            acc_q          <= '0;
            payoff_q       <= '0;
            payoff_valid_q <= 1'b0;
            strike_q       <= '0;
            mode_q         <= MODE_EURO;
        end else begin
            day_cnt_q      <= day_cnt_d;
            path_cnt_q     <= path_cnt_d;
            sum_q          <= sum_d;
            acc_q          <= acc_d;
            payoff_q       <= payoff_d;
            payoff_valid_q <= payoff_valid_d;
            strike_q       <= strike_d;
            mode_q         <= mode_d;
        end
    end

    assign payoff_valid = payoff_valid_q;
    assign payoff       = payoff_q;
    assign busy         = (state_q == ST_ACCUM);
    assign done         = (state_q == ST_DONE);
    assign price        = (state_q == ST_DONE) ? acc_q[LOG2_PATHS +: FP12_W] : '0;

endmodule

// File: tb/tb_payoff_accum.sv
// tb/tb_payoff_accum.sv - table, random and corner-sequence checks of payoff_accum
module tb_payoff_accum;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] strike;
    logic        mode;
    logic        path_valid;
    logic [11:0] path;
    logic        payoff_valid;
    logic [11:0] payoff;
    logic        busy;
    logic        done;
    logic [11:0] price;

    int n_checks;
    int n_fail;

    logic [11:0] beats [8];

    typedef struct {
        string name;
        bit    mode;
        int    strike;
        int    fill;
        int    last;
        int    exp;
    } vec_t;

    vec_t vecs [7];

    payoff_accum #(.NUM_OF_DAYS(8), .NUM_PATHS(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .strike       (strike),
        .mode         (mode),
        .path_valid   (path_valid),
        .path         (path),
        .payoff_valid (payoff_valid),
        .payoff       (payoff),
        .busy         (busy),
        .done         (done),
        .price        (price)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: call payoff on either the final price or the truncated arithmetic mean.
    function automatic int model_payoff(input bit m, input int k);
        int s;
        int u;
        s = 0;
        for (int i = 0; i < 8; i++) s += int'(beats[i]);
        u = m ? (s / 8) : int'(beats[7]);
        return (u > k) ? (u - k) : 0;
    endfunction

    task automatic do_start(input bit m, input int k);
        start  = 1'b1;
        mode   = m;
        strike = 12'(k);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic send_path(input int max_gap);
        for (int i = 0; i < 8; i++) begin
            path_valid = 1'b1;
            path       = beats[i];
            @(negedge clk);
            path_valid = 1'b0;
            if (i < 7 && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic check_payoff(input string name, input int exp, input bit check_low);
        chk({name, "_pv"}, int'(payoff_valid), 1);
        chk(name, int'(payoff), exp);
        if (check_low) begin
            @(negedge clk);
            chk({name, "_pv_low"}, int'(payoff_valid), 0);
        end
    endtask

    task automatic fill_beats(input int fill, input int last);
        for (int i = 0; i < 7; i++) beats[i] = 12'(fill);
        beats[7] = 12'(last);
    endtask

    initial begin
        int finals [4];
        int exp_sum;
        int exp_p;
        bit m;
        int k;

        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        strike     = '0;
        mode       = 1'b0;
        path_valid = 1'b0;
        path       = '0;

        vecs[0] = '{"euro_itm",      1'b0, 256,  280,  320,  64};
        vecs[1] = '{"asian_288",     1'b1, 256,  288,  288,  32};
        vecs[2] = '{"asian_avg255",  1'b1, 256,    0, 2047,   0};
        vecs[3] = '{"euro_otm",      1'b0, 256,  300,  200,   0};
        vecs[4] = '{"euro_atm",      1'b0, 256,  300,  256,   0};
        vecs[5] = '{"asian_trunc",   1'b1, 256,  300,  303,  44};
        vecs[6] = '{"asian_max",     1'b1, 100, 4095, 4095, 3995};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_price", int'(price), 0);
        chk("rst_payoff", int'(payoff), 0);
        chk("rst_pv", int'(payoff_valid), 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_beats(400, 500);
        send_path(0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_pv", int'(payoff_valid), 0);

        foreach (vecs[v]) begin
            do_start(vecs[v].mode, vecs[v].strike);
            chk({vecs[v].name, "_busy"}, int'(busy), 1);
            fill_beats(vecs[v].fill, vecs[v].last);
            send_path(0);
            check_payoff(vecs[v].name, vecs[v].exp, 1'b1);
        end

        for (int r = 0; r < 24; r++) begin
            m = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, 4095));
            if (m) k = k / 2;
            do_start(m, k);
            for (int i = 0; i < 8; i++) beats[i] = 12'($urandom_range(0, 4095));
            send_path(3);
            check_payoff($sformatf("rand%0d", r), model_payoff(m, k), 1'b1);
        end

        finals = '{320, 100, 288, 384};
        exp_sum = 0;
        do_start(1'b0, 256);
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 7; i++) beats[i] = 12'($urandom_range(0, 4095));
            beats[7] = 12'(finals[p]);
            exp_p = model_payoff(1'b0, 256);
            exp_sum += exp_p;
            send_path(p == 1 ? 4 : 0);
            if (p < 3) chk($sformatf("mean_path%0d_done", p), int'(done), 0);
            check_payoff($sformatf("mean_path%0d", p), exp_p, p == 3);
        end
        chk("mean_done", int'(done), 1);
        chk("mean_busy", int'(busy), 0);
        chk("mean_price", int'(price), exp_sum / 4);
        chk("mean_price_const", int'(price), 56);

        for (int i = 0; i < 8; i++) beats[i] = 12'($urandom_range(0, 4095));
        send_path(0);
        chk("done_pv_ignored", int'(payoff_valid), 0);
        chk("done_hold_price", int'(price), 56);
        chk("done_hold_done", int'(done), 1);

        do_start(1'b0, 256);
        chk("restart_done", int'(done), 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_price", int'(price), 0);

        do_start(1'b1, 256);
        for (int i = 0; i < 3; i++) begin
            path_valid = 1'b1;
            path       = 12'd4000;
            @(negedge clk);
        end
        start  = 1'b1;
        mode   = 1'b1;
        strike = 12'd256;
        @(negedge clk);
        start      = 1'b0;
        path_valid = 1'b0;
        fill_beats(288, 288);
        send_path(2);
        check_payoff("abort_fresh", 32, 1'b1);

        do_start(1'b0, 256);
        for (int i = 0; i < 3; i++) begin
            path_valid = 1'b1;
            path       = 12'd1000;
            @(negedge clk);
        end
        path_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        chk("midrst_payoff", int'(payoff), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_price", int'(price), 0);
        chk("midrst_pv", int'(payoff_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(1'b1, 256);
        fill_beats(288, 288);
        send_path(0);
        check_payoff("post_rst_asian", 32, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
